// File: rtl/reset_sequencer_pf.sv
// reset_sequencer_pf: qualifies reset/lock/init, stretches, then releases NUM_CH fabric resets in order.
// Flash*Freeze restore freezes the sequencer and forces every fabric reset output high.
module reset_sequencer_pf #(
    parameter int NUM_CH         = 4,
    parameter int FILT_CYCLES    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int LOCK_TIMEOUT   = 1024
) (
    input  logic              CLK,
    input  logic              INTERNAL_RST,
    input  logic              EXT_RST_N,
    input  logic              PLL_LOCK,
    input  logic              INIT_DONE,
    input  logic              FF_US_RESTORE,
    input  logic              SW_RST_REQ,
    input  logic [NUM_CH-1:0] CH_HOLD,
    output logic [NUM_CH-1:0] FABRIC_RESET_N,
    output logic              RST_DONE,
    output logic              LOCK_TIMEOUT_ERR,
    output logic [1:0]        STATE
);
    localparam int FW   = $clog2(FILT_CYCLES + 1);
    localparam int CMAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(LOCK_TIMEOUT + 1);
    localparam int IW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {WAIT_COND = 2'd0, STRETCH = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;

    state_t            state, state_nxt;
    logic [3:0]        sync1, sync2;
    logic [FW-1:0]     filt_cnt, filt_nxt;
    logic              ready_q, ready_raw, freeze;
    logic [TW-1:0]     to_cnt, to_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     idx, idx_nxt, nxt_ch;
    logic [NUM_CH-1:0] rel, rel_nxt;
    logic              done_nxt, err_nxt;

    assign ready_raw      = &sync2[2:0];
    assign freeze         = sync2[3];
    assign filt_nxt       = !ready_raw ? '0 : (filt_cnt == FW'(FILT_CYCLES)) ? filt_cnt : filt_cnt + 1'b1;
    assign nxt_ch         = idx + 1'b1;
    assign FABRIC_RESET_N = rel | {NUM_CH{FF_US_RESTORE}};
    assign STATE          = state;

    always_ff @(posedge CLK or negedge INTERNAL_RST) begin
        if (!INTERNAL_RST) begin
            sync1            <= '0;
            sync2            <= '0;
            filt_cnt         <= '0;
            ready_q          <= 1'b0;
            state            <= WAIT_COND;
            to_cnt           <= '0;
            cnt              <= '0;
            idx              <= '0;
            rel              <= '0;
            RST_DONE         <= 1'b0;
            LOCK_TIMEOUT_ERR <= 1'b0;
        end else begin
            sync1            <= {FF_US_RESTORE, INIT_DONE, PLL_LOCK, EXT_RST_N};
            sync2            <= sync1;
            filt_cnt         <= filt_nxt;
            ready_q          <= filt_nxt == FW'(FILT_CYCLES);
            state            <= state_nxt;
            to_cnt           <= to_nxt;
            cnt              <= cnt_nxt;
            idx              <= idx_nxt;
            rel              <= rel_nxt;
            RST_DONE         <= done_nxt;
            LOCK_TIMEOUT_ERR <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        to_nxt    = to_cnt;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rel_nxt   = rel;
        done_nxt  = RST_DONE;
        err_nxt   = LOCK_TIMEOUT_ERR;
        if (!freeze) begin
            if (state == WAIT_COND) begin
                rel_nxt  = '0;
                done_nxt = 1'b0;
                if (ready_q) begin
                    state_nxt = STRETCH;
                    err_nxt   = 1'b0;
                    to_nxt    = '0;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else begin
                    to_nxt  = (to_cnt == TW'(LOCK_TIMEOUT)) ? to_cnt : to_cnt + 1'b1;
                    err_nxt = LOCK_TIMEOUT_ERR | (to_nxt == TW'(LOCK_TIMEOUT));
                end
            end else if (!ready_q || SW_RST_REQ) begin
                // qualifier loss outranks a coincident software request
                state_nxt = ready_q ? STRETCH : WAIT_COND;
                rel_nxt   = '0;
                done_nxt  = 1'b0;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end else if (state == STRETCH) begin
                if (cnt == CW'(STRETCH_CYCLES - 1)) begin
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    rel_nxt[0] = 1'b1;
                    state_nxt  = (NUM_CH == 1) ? RUN : RELEASE;
                    done_nxt   = NUM_CH == 1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (state == RELEASE) begin
                if (cnt != CW'(STAGE_GAP - 1)) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (!CH_HOLD[nxt_ch]) begin
                    rel_nxt[nxt_ch] = 1'b1;
                    idx_nxt         = nxt_ch;
                    cnt_nxt         = '0;
                    if (nxt_ch == IW'(NUM_CH - 1)) begin
                        state_nxt = RUN;
                        done_nxt  = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reset_sequencer_pf.sv
// tb_reset_sequencer_pf: randomized scenarios checked against release edges derived arithmetically.
// Edge 1 is the first posedge after INTERNAL_RST release; outputs are sampled at the following negedge.
module tb_reset_sequencer_pf;
    localparam int NUM_CH = 4;
    localparam int F      = 4;
    localparam int S      = 16;
    localparam int G      = 8;
    localparam int LT     = 1024;
    localparam int N0     = 3 + F + S;

    logic              CLK = 1'b0;
    logic              INTERNAL_RST = 1'b0;
    logic              EXT_RST_N = 1'b1, PLL_LOCK = 1'b1, INIT_DONE = 1'b1;
    logic              FF_US_RESTORE = 1'b0, SW_RST_REQ = 1'b0;
    logic [NUM_CH-1:0] CH_HOLD = '0;
    logic [NUM_CH-1:0] FABRIC_RESET_N;
    logic              RST_DONE, LOCK_TIMEOUT_ERR;
    logic [1:0]        STATE;

    reset_sequencer_pf #(
        .NUM_CH(NUM_CH), .FILT_CYCLES(F), .STRETCH_CYCLES(S), .STAGE_GAP(G), .LOCK_TIMEOUT(LT)
    ) dut (
        .CLK(CLK), .INTERNAL_RST(INTERNAL_RST), .EXT_RST_N(EXT_RST_N), .PLL_LOCK(PLL_LOCK),
        .INIT_DONE(INIT_DONE), .FF_US_RESTORE(FF_US_RESTORE), .SW_RST_REQ(SW_RST_REQ),
        .CH_HOLD(CH_HOLD), .FABRIC_RESET_N(FABRIC_RESET_N), .RST_DONE(RST_DONE),
        .LOCK_TIMEOUT_ERR(LOCK_TIMEOUT_ERR), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int hold_until[NUM_CH];
    int sw_edge, ext_low, pll_low_until, ff_on, ff_off;
    int rise[NUM_CH];
    int done_rise;
    logic [NUM_CH-1:0] prev_fab;
    logic prev_done;
    int exp_rel[NUM_CH];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // drive inputs for the upcoming edge cyc+1; Flash*Freeze follows the current edge count
    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) CH_HOLD[k] = (cyc + 1 <= hold_until[k]);
        SW_RST_REQ    = (cyc + 1 == sw_edge);
        EXT_RST_N     = !(cyc + 1 == ext_low);
        PLL_LOCK      = (cyc + 1 > pll_low_until);
        FF_US_RESTORE = (cyc >= ff_on) && (cyc < ff_off);
        #1;
    endtask

    task automatic clear_rise();
        for (int k = 0; k < NUM_CH; k++) rise[k] = -1;
        done_rise = -1;
        prev_fab  = FABRIC_RESET_N;
        prev_done = RST_DONE;
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        for (int k = 0; k < NUM_CH; k++)
            if (FABRIC_RESET_N[k] && !prev_fab[k] && rise[k] < 0) rise[k] = cyc;
        if (RST_DONE && !prev_done && done_rise < 0) done_rise = cyc;
        prev_fab  = FABRIC_RESET_N;
        prev_done = RST_DONE;
        drive();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic start();
        INTERNAL_RST = 1'b0;
        for (int k = 0; k < NUM_CH; k++) hold_until[k] = 0;
        sw_edge = 0; ext_low = 0; pll_low_until = 0; ff_on = 0; ff_off = 0;
        INIT_DONE = 1'b1;
        cyc = 0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic go();
        @(negedge CLK);
        cyc = 0;
        drive();
        INTERNAL_RST = 1'b1;
        #1;
        clear_rise();
        check("rst_fab", int'(FABRIC_RESET_N), 0);
        check("rst_state", int'(STATE), 0);
        check("rst_done", int'(RST_DONE), 0);
        check("rst_err", int'(LOCK_TIMEOUT_ERR), 0);
    endtask

    task automatic check_rises(input string tag, input int base);
        for (int k = 0; k < NUM_CH; k++) check($sformatf("%s_ch%0d", tag, k), rise[k], base + k * G);
        check({tag, "_done"}, done_rise, base + (NUM_CH - 1) * G);
    endtask

    initial begin
        int r, p, z, l, e;
        // nominal sequence; a software request while still qualifying is ignored
        start();
        sw_edge = 4;
        go();
        run_to(6);  check("nom_state6", int'(STATE), 0);
        run_to(7);  check("nom_state7", int'(STATE), 1);
        run_to(22); check("nom_state22", int'(STATE), 1);
        run_to(23); check("nom_state23", int'(STATE), 2);
        run_to(N0 + (NUM_CH - 1) * G + 2);
        check_rises("nom", N0);
        check("nom_state_run", int'(STATE), 3);

        // software re-reset from RUN restarts at STRETCH without filtering
        r = N0 + (NUM_CH - 1) * G + 3 + int'($urandom_range(0, 20));
        sw_edge = r;
        clear_rise();
        run_to(r);
        check("sw_fab", int'(FABRIC_RESET_N), 0);
        check("sw_state", int'(STATE), 1);
        check("sw_done", int'(RST_DONE), 0);
        run_to(r + S + (NUM_CH - 1) * G + 3);
        check_rises("sw", r + S);

        // per-channel holds: release = max(gap expiry, first edge sampling hold low)
        for (int it = 0; it < 4; it++) begin
            start();
            for (int k = 0; k < NUM_CH; k++)
                hold_until[k] = (it == 0) ? ((k == 2) ? 60 : 0)
                              : ($urandom_range(0, 1) != 0 ? int'($urandom_range(20, 90)) : 0);
            exp_rel[0] = N0;
            for (int k = 1; k < NUM_CH; k++)
                exp_rel[k] = (exp_rel[k-1] + G > hold_until[k] + 1) ? exp_rel[k-1] + G : hold_until[k] + 1;
            go();
            run_to(exp_rel[NUM_CH-1] + 4);
            for (int k = 0; k < NUM_CH; k++) check($sformatf("hold%0d_ch%0d", it, k), rise[k], exp_rel[k]);
            check($sformatf("hold%0d_done", it), done_rise, exp_rel[NUM_CH-1]);
        end

        // lock timeout: flag at edge LT, cleared on the WAIT_COND->STRETCH edge
        start();
        l = 1030 + int'($urandom_range(0, 170));
        pll_low_until = l;
        go();
        run_to(LT - 1); check("to_err_before", int'(LOCK_TIMEOUT_ERR), 0);
        run_to(LT);     check("to_err_set", int'(LOCK_TIMEOUT_ERR), 1);
        e = l + 1;
        run_to(e + 1 + F);
        check("to_err_hold", int'(LOCK_TIMEOUT_ERR), 1);
        check("to_state_wait", int'(STATE), 0);
        run_to(e + 2 + F);
        check("to_err_clr", int'(LOCK_TIMEOUT_ERR), 0);
        check("to_state_str", int'(STATE), 1);
        run_to(e + 2 + F + S + (NUM_CH - 1) * G + 2);
        check_rises("to", e + 2 + F + S);

        // one-cycle external reset glitch after ch1 released
        start();
        p = N0 + G + 1 + int'($urandom_range(0, 4));
        ext_low = p;
        go();
        run_to(p + 2);
        check("glitch_fab_pre", int'(FABRIC_RESET_N), 3);
        check("glitch_state_pre", int'(STATE), 2);
        run_to(p + 3);
        check("glitch_fab", int'(FABRIC_RESET_N), 0);
        check("glitch_state", int'(STATE), 0);
        clear_rise();
        run_to(p + 3 + F + S + (NUM_CH - 1) * G + 2);
        check_rises("glitch", p + 3 + F + S);

        // Flash*Freeze mid-STRETCH, then async reset mid-RELEASE
        start();
        z = 8 + int'($urandom_range(0, 12));
        ff_on = z; ff_off = z + 50;
        go();
        run_to(z);
        check("ff_fab_on", int'(FABRIC_RESET_N), (1 << NUM_CH) - 1);
        check("ff_state_on", int'(STATE), 1);
        run_to(z + 30);
        check("ff_fab_mid", int'(FABRIC_RESET_N), (1 << NUM_CH) - 1);
        check("ff_state_mid", int'(STATE), 1);
        check("ff_done_mid", int'(RST_DONE), 0);
        run_to(z + 50);
        check("ff_fab_off", int'(FABRIC_RESET_N), 0);
        check("ff_state_off", int'(STATE), 1);
        clear_rise();
        run_to(N0 + 50 + G + 2);
        check("ff_ch0", rise[0], N0 + 50);
        check("ff_ch1", rise[1], N0 + 50 + G);
        #2 INTERNAL_RST = 1'b0;
        #1;
        check("arst_fab", int'(FABRIC_RESET_N), 0);
        check("arst_state", int'(STATE), 0);
        check("arst_done", int'(RST_DONE), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reset_sequencer_pf.md
Name: reset_sequencer_pf

Overview:
Parametrised multi-channel fabric reset sequencer. It qualifies external reset, PLL lock and device init-done, then stretches the release. It de-asserts NUM_CH fabric reset outputs one at a time, in channel order, with a programmable gap between channels. It also supports per-channel hold, a software re-reset request, lock-timeout flagging and a Flash*Freeze restore override. It sits between the device reset/PLL primitives and the per-domain fabric resets of the subsystem.

Parameters:
NUM_CH, 4, number of fabric reset channels (>=1)
FILT_CYCLES, 4, consecutive cycles all qualifiers must be high before acceptance (>=1)
STRETCH_CYCLES, 16, cycles between acceptance and channel 0 release (>=1)
STAGE_GAP, 8, cycles between consecutive channel releases (>=1)
LOCK_TIMEOUT, 1024, WAIT_COND cycles before LOCK_TIMEOUT_ERR is set (>=1)

Ports:
CLK  in  1  sequencer clock
INTERNAL_RST  in  1  asynchronous active-low reset
EXT_RST_N  in  1  external reset, active-low, asynchronous
PLL_LOCK  in  1  PLL lock, asynchronous
INIT_DONE  in  1  device init complete, asynchronous
FF_US_RESTORE  in  1  Flash*Freeze restore, asynchronous level
SW_RST_REQ  in  1  single-cycle software re-reset request, CLK domain
CH_HOLD  in  NUM_CH  per-channel release hold, CLK domain
FABRIC_RESET_N  out  NUM_CH  per-channel fabric reset, active-low
RST_DONE  out  1  all channels released
LOCK_TIMEOUT_ERR  out  1  sticky qualifier-timeout flag
STATE  out  2  FSM state: 0 WAIT_COND, 1 STRETCH, 2 RELEASE, 3 RUN

Behaviour:
- Reset domain: INTERNAL_RST asynchronous, active-low; clock CLK. On assertion, the following happen immediately:
  - state WAIT_COND
  - internal FABRIC_RESET_N bits 0
  - RST_DONE 0, LOCK_TIMEOUT_ERR 0
  - all counters and synchronisers 0
- Synchronisation: EXT_RST_N, PLL_LOCK, INIT_DONE and FF_US_RESTORE each pass through a 2-flop synchroniser.
- Qualifier:
  - ready_raw is the AND of the three synced qualifiers.
  - Filter counter increments while ready_raw is high and clears the same edge ready_raw is low.
  - ready_q is set when the count reaches FILT_CYCLES.
  - ready_q drops one edge after ready_raw drops.
- WAIT_COND:
  - All channels low.
  - Timeout counter saturates at LOCK_TIMEOUT and sets LOCK_TIMEOUT_ERR on reaching it.
  - On ready_q, go to STRETCH, clear LOCK_TIMEOUT_ERR and clear the timeout counter.
- STRETCH: count STRETCH_CYCLES, then go to RELEASE and set FABRIC_RESET_N[0] on the same edge.
- RELEASE:
  - Gap counter counts STAGE_GAP, then releases channel k+1.
  - If CH_HOLD[k+1] is high when the gap expires, the gap counter holds and channel k+1 releases on the first edge after CH_HOLD[k+1] is sampled low.
  - Released channels stay released.
  - After the last channel, go to RUN; RST_DONE rises on the same edge as the last channel.
  - If NUM_CH=1, go STRETCH to RUN directly.
  - CH_HOLD is ignored in RUN and for channel 0.
- Timing with no holds: FABRIC_RESET_N[0] rises at edge N0 = 3+FILT_CYCLES+STRETCH_CYCLES, counted from the first edge sampling all qualifiers high; channel k rises at N0 + k*STAGE_GAP.
- Qualifier loss (ready_q low) in STRETCH/RELEASE/RUN: next edge all channels 0, RST_DONE 0, go to WAIT_COND.
- SW_RST_REQ in STRETCH/RELEASE/RUN:
  - Next edge: all channels 0, RST_DONE 0, counters cleared, go to STRETCH (no re-filtering if ready_q is high).
  - Ignored in WAIT_COND.
  - If qualifier loss coincides, loss wins and the FSM goes to WAIT_COND.
- Freeze: while synced FF_US_RESTORE is high, the FSM, counters and RST_DONE hold. The qualifier filter keeps running, but loss is acted on only after freeze ends.
- Output override: FABRIC_RESET_N[k] = internal_rel[k] OR raw FF_US_RESTORE (combinational, unsynchronised), for every k.
- Width rules: counters use $clog2(param+1) bits and never wrap.

Test Plan:
- Defaults, all qualifiers high from cycle 0, CH_HOLD=0 -> FABRIC_RESET_N[0..3] rise at edges 23/31/39/47; RST_DONE rises at 47; STATE 0→1→2→3.
- CH_HOLD[2]=1 until edge 60 -> ch2 rises at edge 61, ch3 at 69, RST_DONE at 69; ch0/ch1 unchanged.
- PLL_LOCK low for 1200 cycles after reset -> LOCK_TIMEOUT_ERR=1 from edge 1024. When lock rises, the flag clears on the WAIT_COND→STRETCH edge, then the normal sequence follows.
- In RUN, SW_RST_REQ pulse -> all channels 0 next edge; STATE=1; ch0 re-releases STRETCH_CYCLES later, with no filter delay.
- In RELEASE after ch1, EXT_RST_N pulse low 1 cycle -> all channels 0 within 4 edges; STATE=0; the full filter+stretch sequence reruns.
- FF_US_RESTORE high mid-STRETCH for 50 cycles -> all FABRIC_RESET_N=1 immediately; STATE frozen. On release, outputs return to 0 and the stretch resumes from the held count. Also assert INTERNAL_RST mid-RELEASE -> all outputs 0 asynchronously.
